uart_loader: RTL and testbench

Frame-level controller that sits behind the UART receiver and sequences its byte stream into memory writes. It consumes the receiver's `ready`/`rbyte` strobe pair, parses a fixed framed protocol (sync, command, address, length, payload, checksum) and drives a single-byte memory write port. It also holds the rest of the system via `busy` while a frame is in flight. Used to upload code/data into on-chip RAM over the 460800-baud serial link.

---
 rtl/uart_loader_if.sv | 32 +++
 rtl/uart_loader.sv | 190 +++++++++++++++++++
 tb/tb_uart_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// uart_loader_if -- bundles the signals around the frame loader.
//
// Receiver side : ready (1-cycle strobe), rbyte (received byte)
// Memory side   : address, wdata, we (single-byte write port)
// Status        : busy (frame in flight), done / error (1-cycle pulses)
//
// Modports:
//   master - the loader itself: consumes the byte stream, drives the
//            memory write port and the status outputs.
//   slave  - the environment: feeds bytes, observes writes and status.
interface uart_loader_if #(
  parameter int ADDR_W = 16
);
  logic              ready;
  logic [7:0]        rbyte;
  logic [ADDR_W-1:0] address;
  logic [7:0]        wdata;
  logic              we;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  ready, rbyte,
    output address, wdata, we, busy, done, error
  );

  modport slave (
    output ready, rbyte,
    input  address, wdata, we, busy, done, error
  );
endinterface

// File: rtl/uart_loader.sv
// uart_loader -- turns the UART receiver byte stream into memory writes.
//
// Frame: SYNC, CMD, ADDR_L, ADDR_H, LEN_L, LEN_H, LEN payload bytes, SUM.
// CMD 8'h01 writes the payload to consecutive addresses starting at ADDR
// (wrapping modulo 2^ADDR_W). SUM is the modulo-256 sum of every byte
// after SYNC up to the last payload byte.
//
// Ports:
//   clock25 - system clock
//   reset   - synchronous, active-high reset
//   bus     - uart_loader_if.master: ready/rbyte in, address/wdata/we,
//             busy, done, error out (all outputs registered)
//
// Parameters:
//   ADDR_W  - address / length width (must be at least 8)
//   TIMEOUT - idle cycles tolerated between bytes inside a frame
//   SYNC    - frame start byte
module uart_loader #(
  parameter int          ADDR_W  = 16,
  parameter int          TIMEOUT = 250000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input logic          clock25,
  input logic          reset,
  uart_loader_if.master bus
);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam int         CNT_W     = $clog2(TIMEOUT + 1);
  // The counter holds (idle cycles - 1); the TIMEOUT-th idle cycle is the
  // one where it reads TIMEOUT-1. A strobe in that very cycle still wins.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADR_L,
    S_ADR_H,
    S_LEN_L,
    S_LEN_H,
    S_DATA,
    S_SUM
  } state_t;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] ptr_q,     ptr_d;      // next write address
  logic [ADDR_W-1:0] rem_q,     rem_d;      // length / bytes still to write
  logic [7:0]        sum_q,     sum_d;      // running checksum
  logic [CNT_W-1:0]  idle_q,    idle_d;     // cycles since last strobe
  logic [ADDR_W-1:0] address_q, address_d;
  logic [7:0]        wdata_q,   wdata_d;
  logic              we_q,      we_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              error_q,   error_d;

  logic              timeout;
  logic [ADDR_W-1:0] len_full;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    sum_d     = sum_q;
    idle_d    = idle_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    timeout   = 1'b0;
    len_full  = ADDR_W'({bus.rbyte, rem_q[7:0]});

    // Inter-byte watchdog: only runs while a frame is open.
    if (state_q == S_IDLE || bus.ready) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      timeout = 1'b1;
    end else begin
      idle_d = idle_q + CNT_W'(1);
    end

    if (timeout) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end else if (bus.ready) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rbyte == SYNC) begin
            state_d = S_CMD;
            ptr_d   = '0;
            rem_d   = '0;
            sum_d   = '0;
          end
        end
        S_CMD: begin
          if (bus.rbyte == CMD_WRITE) begin
            state_d = S_ADR_L;
            sum_d   = bus.rbyte;
          end else begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end
        end
        S_ADR_L: begin
          ptr_d   = ADDR_W'(bus.rbyte);
          sum_d   = sum_q + bus.rbyte;
          state_d = S_ADR_H;
        end
        S_ADR_H: begin
          ptr_d   = ADDR_W'({bus.rbyte, ptr_q[7:0]});
          sum_d   = sum_q + bus.rbyte;
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          rem_d   = ADDR_W'(bus.rbyte);
          sum_d   = sum_q + bus.rbyte;
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          rem_d   = len_full;
          sum_d   = sum_q + bus.rbyte;
          state_d = (len_full == '0) ? S_SUM : S_DATA;
        end
        S_DATA: begin
          // The output address only moves on a write; the internal
          // pointer already points at the next target afterwards.
          we_d      = 1'b1;
          address_d = ptr_q;
          wdata_d   = bus.rbyte;
          ptr_d     = ptr_q + ADDR_W'(1);
          rem_d     = rem_q - ADDR_W'(1);
          sum_d     = sum_q + bus.rbyte;
          if (rem_q == ADDR_W'(1)) begin
            state_d = S_SUM;
          end
        end
        S_SUM: begin
          state_d = S_IDLE;
          if (bus.rbyte == sum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      idle_q    <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      sum_q     <= sum_d;
      idle_q    <= idle_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.address = address_q;
  assign bus.wdata   = wdata_q;
  assign bus.we      = we_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader -- self-checking bench for uart_loader.
// Directed frames come from a table of {bytes, expected writes, expected
// status}; random frames are checked against a frame-level protocol model.
module tb_uart_loader;

  localparam int         TO   = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(16)) bus ();

  uart_loader #(
    .ADDR_W (16),
    .TIMEOUT(TO),
    .SYNC   (SYNC)
  ) dut (
    .clock25(clk),
    .reset  (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- cycle counter and output monitor ----------------
  int         cyc = 0;
  logic       rdy_prev = 1'b0;
  int         strobe_cyc = 0;
  int         evt_cyc = -1;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [23:0] got_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_prev <= bus.ready;
  end

  always @(negedge clk) begin
    if (bus.we) begin
      got_q.push_back({bus.address, bus.wdata});
      chk("we_follows_ready", {31'd0, rdy_prev}, 32'd1);
    end
    if (bus.done || bus.error) begin
      evt_cyc = cyc;
      chk("done_error_exclusive", {31'd0, bus.done & bus.error}, 32'd0);
      chk("busy_falls_with_pulse", {31'd0, bus.busy}, 32'd0);
    end
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    evt_cyc  = -1;
  endtask

  // ---------------- driver ----------------
  // Waits `gap` edges after the previous strobe, then holds ready for one
  // cycle; returns #1 after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    bus.ready = 1'b1;
    bus.rbyte = b;
    @(posedge clk);
    #1;
    bus.ready  = 1'b0;
    strobe_cyc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[k]) send_byte(f[k], $urandom_range(1, 6));
  endtask

  // ---------------- expectations ----------------
  logic [23:0] exp_q[$];
  int          exp_dn;
  int          exp_er;

  // Protocol-level model: find SYNC, interpret the fields, list the writes.
  task automatic model_frame(input logic [7:0] f[$]);
    int i, s, addr, len;
    exp_q.delete();
    exp_dn = 0;
    exp_er = 0;
    i = 0;
    while (i < f.size() && f[i] != SYNC) i++;
    if (i + 1 >= f.size()) return;
    if (f[i+1] != 8'h01) begin
      exp_er = 1;
      return;
    end
    addr = int'(f[i+2]) + 256 * int'(f[i+3]);
    len  = int'(f[i+4]) + 256 * int'(f[i+5]);
    s = int'(f[i+1]) + int'(f[i+2]) + int'(f[i+3]) + int'(f[i+4]) + int'(f[i+5]);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back({16'((addr + k) % 65536), f[i+6+k]});
      s += int'(f[i+6+k]);
    end
    if (int'(f[i+6+len]) == s % 256) exp_dn = 1;
    else exp_er = 1;
  endtask

  task automatic finish_frame(input string name);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_nwrites"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({name, "_write"}, {8'd0, got_q[k]}, {8'd0, exp_q[k]});
    chk({name, "_done"}, done_cnt, exp_dn);
    chk({name, "_error"}, err_cnt, exp_er);
    if (exp_dn != 0 || exp_er != 0)
      chk({name, "_pulse_latency"}, evt_cyc, strobe_cyc);
    chk({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    $display("frame %s: writes=%0d done=%0d error=%0d", name, got_q.size(), done_cnt, err_cnt);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_address"}, {16'd0, bus.address}, 32'd0);
    chk({name, "_wdata"},   {24'd0, bus.wdata},   32'd0);
    chk({name, "_we"},      {31'd0, bus.we},      32'd0);
    chk({name, "_busy"},    {31'd0, bus.busy},    32'd0);
    chk({name, "_done"},    {31'd0, bus.done},    32'd0);
    chk({name, "_error"},   {31'd0, bus.error},   32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [7:0]  b  [0:9];
    int          n;
    int          nwe;
    logic [15:0] wa [0:2];
    logic [7:0]  wd [0:2];
    int          dn;
    int          er;
  } vec_t;

  vec_t vec [0:4];
  logic [7:0] fq[$];

  initial begin
    vec[0].name = "badcmd_noise";
    vec[0].b  = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[0].n  = 4;  vec[0].nwe = 0;
    vec[0].wa = '{16'h0, 16'h0, 16'h0}; vec[0].wd = '{8'h0, 8'h0, 8'h0};
    vec[0].dn = 0;  vec[0].er = 1;

    vec[1].name = "good";
    vec[1].b  = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h7A};
    vec[1].n  = 10; vec[1].nwe = 3;
    vec[1].wa = '{16'h1000, 16'h1001, 16'h1002}; vec[1].wd = '{8'h11, 8'h22, 8'h33};
    vec[1].dn = 1;  vec[1].er = 0;

    vec[2].name = "badsum";
    vec[2].b  = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h7B};
    vec[2].n  = 10; vec[2].nwe = 3;
    vec[2].wa = '{16'h1000, 16'h1001, 16'h1002}; vec[2].wd = '{8'h11, 8'h22, 8'h33};
    vec[2].dn = 0;  vec[2].er = 1;

    vec[3].name = "zero_len";
    vec[3].b  = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h00, 8'h00, 8'h47, 8'h00, 8'h00, 8'h00};
    vec[3].n  = 7;  vec[3].nwe = 0;
    vec[3].wa = '{16'h0, 16'h0, 16'h0}; vec[3].wd = '{8'h0, 8'h0, 8'h0};
    vec[3].dn = 1;  vec[3].er = 0;

    vec[4].name = "addr_wrap";
    vec[4].b  = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h66, 8'h00};
    vec[4].n  = 9;  vec[4].nwe = 2;
    vec[4].wa = '{16'hFFFF, 16'h0000, 16'h0}; vec[4].wd = '{8'hAA, 8'hBB, 8'h0};
    vec[4].dn = 1;  vec[4].er = 0;

    bus.ready = 1'b0;
    bus.rbyte = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed frames
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      fq.delete();
      for (int k = 0; k < vec[v].n; k++) fq.push_back(vec[v].b[k]);
      exp_q.delete();
      for (int k = 0; k < vec[v].nwe; k++) exp_q.push_back({vec[v].wa[k], vec[v].wd[k]});
      exp_dn = vec[v].dn;
      exp_er = vec[v].er;
      send_frame(fq);
      finish_frame(vec[v].name);
      #1;
    end

    // Timeout: frame stalls after ADDR_L
    clear_mon();
    send_byte(8'hA5, 2);
    @(negedge clk);
    chk("busy_rise_after_sync", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h01, 1);
    send_byte(8'h00, 2);
    for (int w = 0; w < TO + 10 && err_cnt == 0; w++) @(negedge clk);
    chk("timeout_error", err_cnt, 1);
    chk("timeout_latency", evt_cyc, strobe_cyc + TO);
    chk("timeout_busy", {31'd0, bus.busy}, 32'd0);
    chk("timeout_done", done_cnt, 0);
    chk("timeout_nwrites", got_q.size(), 0);
    $display("frame timeout: error=%0d at cycle offset %0d", err_cnt, evt_cyc - strobe_cyc);
    @(posedge clk);
    #1;

    // Byte arriving in the last allowed cycle is accepted
    clear_mon();
    fq.delete();
    for (int k = 0; k < 10; k++) fq.push_back(vec[1].b[k]);
    foreach (fq[k]) send_byte(fq[k], (k == 3) ? TO - 1 : 2);
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back({vec[1].wa[k], vec[1].wd[k]});
    exp_dn = 1;
    exp_er = 0;
    finish_frame("edge_of_timeout");
    #1;

    // Reset in the middle of the payload
    clear_mon();
    fq = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h03, 8'h00, 8'h11, 8'h22};
    send_frame(fq);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h33, 2);
    send_byte(8'h7A, 2);
    exp_q = '{{16'h2000, 8'h11}, {16'h2001, 8'h22}};
    exp_dn = 0;
    exp_er = 0;
    finish_frame("mid_reset");
    #1;
    clear_mon();
    fq.delete();
    for (int k = 0; k < 10; k++) fq.push_back(vec[1].b[k]);
    model_frame(fq);
    send_frame(fq);
    finish_frame("after_reset");
    #1;

    // Random frames against the protocol model
    for (int r = 0; r < 25; r++) begin
      int len;
      int s;
      logic [7:0] cmd;
      logic [7:0] by;
      fq.delete();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        by = 8'($urandom_range(0, 255));
        if (by == SYNC) by = 8'h00;
        fq.push_back(by);
      end
      fq.push_back(SYNC);
      cmd = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
      fq.push_back(cmd);
      if (cmd == 8'h01) begin
        len = int'($urandom_range(0, 5));
        fq.push_back(8'($urandom_range(0, 255)));
        fq.push_back(8'($urandom_range(0, 255)));
        fq.push_back(8'(len));
        fq.push_back(8'h00);
        s = 0;
        for (int k = 0; k < len; k++) fq.push_back(8'($urandom_range(0, 255)));
        for (int k = fq.size() - 5 - len; k < fq.size(); k++) s += int'(fq[k]);
        if ($urandom_range(0, 4) == 0) s += int'($urandom_range(1, 255));
        fq.push_back(8'(s % 256));
      end
      clear_mon();
      model_frame(fq);
      send_frame(fq);
      finish_frame($sformatf("random%0d", r));
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
